// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising checker that predicts a 16-bit Fibonacci LFSR stream and counts errors
module lfsr_checker #(
   parameter int LOCK_CNT   = 4,
   parameter int UNLOCK_CNT = 3,
   parameter int ERR_W      = 16,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   input  logic [15:0]      in_data,
   input  logic             clr,
   output logic             locked,
   output logic             err_pulse,
   output logic             lock_lost,
   output logic [ERR_W-1:0] err_count,
   output logic [CNT_W-1:0] word_count
);
   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam int XW = $clog2(UNLOCK_CNT + 1);
   typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
   state_t state, state_n;
   logic [15:0] pred, pred_n;
   logic [MW-1:0] match, match_n;
   logic [XW-1:0] miss, miss_n;
   logic hit, err_n, lost_n;
   logic [ERR_W-1:0] err_count_n;
   logic [CNT_W-1:0] word_count_n;
   function automatic logic [15:0] nxt(input logic [15:0] q);
      return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
   endfunction
   assign hit = in_data == pred;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         state <= HUNT;
         pred  <= '0;
         match <= '0;
         miss  <= '0;
      end else begin
         state <= state_n;
         pred  <= pred_n;
         match <= match_n;
         miss  <= miss_n;
      end
   always_comb begin
      state_n = state;
      pred_n  = pred;
      match_n = match;
      miss_n  = miss;
      if (in_valid)
         case (state)
            HUNT:
               if (in_data != '0) begin
                  pred_n  = nxt(in_data);
                  match_n = '0;
                  state_n = VERIFY;
               end
            VERIFY:
               if (hit) begin
                  pred_n  = nxt(pred);
                  match_n = match + 1'b1;
                  if (match_n == MW'(LOCK_CNT)) begin
                     state_n = LOCKED;
                     miss_n  = '0;
                  end
               end else begin
                  // a zero word is the lock-up state, so it cannot seed a new prediction
                  pred_n  = nxt(in_data);
                  match_n = '0;
                  state_n = (in_data == '0) ? HUNT : VERIFY;
               end
            LOCKED: begin
               // flywheel: prediction advances on its own, corrupted words never reseed
               pred_n = nxt(pred);
               miss_n = hit ? '0 : miss + 1'b1;
               if (!hit && miss_n == XW'(UNLOCK_CNT)) begin
                  state_n = HUNT;
                  match_n = '0;
               end
            end
            default: state_n = HUNT;
         endcase
   end
   always_comb begin
      err_n        = in_valid && state == LOCKED && !hit;
      lost_n       = err_n && miss_n == XW'(UNLOCK_CNT);
      err_count_n  = clr ? '0 : (err_n && err_count != '1) ? err_count + 1'b1 : err_count;
      word_count_n = clr ? '0 : (in_valid && state == LOCKED && word_count != '1) ? word_count + 1'b1 : word_count;
   end
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         locked     <= 1'b0;
         err_pulse  <= 1'b0;
         lock_lost  <= 1'b0;
         err_count  <= '0;
         word_count <= '0;
      end else begin
         locked     <= state_n == LOCKED;
         err_pulse  <= err_n;
         lock_lost  <= lost_n;
         err_count  <= err_count_n;
         word_count <= word_count_n;
      end
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: directed checks of lfsr_checker lock, error, unlock, clear and saturation behaviour
module tb_lfsr_checker;
   logic clk = 1'b0, resetn = 1'b0, in_valid = 1'b0, clr = 1'b0;
   logic [15:0] in_data = '0, cur;
   logic locked, err_pulse, lock_lost, l4, e4, ll4;
   logic [15:0] err_count;
   logic [31:0] word_count;
   logic [3:0] ec4, wc4;
   int n_cmp = 0, n_bad = 0;
   always #5 clk = ~clk;
   lfsr_checker dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data), .clr(clr),
      .locked(locked), .err_pulse(err_pulse), .lock_lost(lock_lost),
      .err_count(err_count), .word_count(word_count)
   );
   lfsr_checker #(.ERR_W(4), .CNT_W(4)) u4 (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data), .clr(clr),
      .locked(l4), .err_pulse(e4), .lock_lost(ll4),
      .err_count(ec4), .word_count(wc4)
   );
   function automatic logic [15:0] nxt(input logic [15:0] q);
      return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask
   task automatic drive(input logic v, input logic [15:0] w, input logic c);
      in_valid = v;
      in_data  = w;
      clr      = c;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      clr      = 1'b0;
   endtask
   task automatic good();
      drive(1'b1, cur, 1'b0);
      cur = nxt(cur);
   endtask
   task automatic bad(input logic [15:0] w);
      drive(1'b1, w, 1'b0);
      cur = nxt(cur);
   endtask
   initial begin
      #12;
      chk("rst_locked", locked, 0);
      chk("rst_err_pulse", err_pulse, 0);
      chk("rst_lock_lost", lock_lost, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_word_count", word_count, 0);
      resetn = 1'b1;
      @(posedge clk);
      #1;
      drive(1'b1, 16'hACE1, 1'b0);
      chk("seed_not_locked", locked, 0);
      drive(1'b1, 16'h59C3, 1'b0);
      cur = nxt(16'h59C3);
      good();
      good();
      chk("lock_after_4", locked, 0);
      good();
      chk("lock_after_5", locked, 1);
      chk("lock_err_count", err_count, 0);
      chk("lock_word_count", word_count, 0);
      good();
      chk("first_counted_word", word_count, 1);
      bad(cur ^ 16'h0001);
      chk("bit_err_pulse", err_pulse, 1);
      chk("bit_err_count", err_count, 1);
      chk("bit_err_locked", locked, 1);
      chk("bit_err_words", word_count, 2);
      good();
      chk("bit_err_pulse_drop", err_pulse, 0);
      good();
      chk("bit_err_no_more", err_count, 1);
      chk("bit_err_words2", word_count, 4);
      drive(1'b0, 16'h0, 1'b1);
      chk("clr_err_count", err_count, 0);
      chk("clr_word_count", word_count, 0);
      chk("clr_keeps_lock", locked, 1);
      bad(16'h1234);
      chk("miss1_err", err_count, 1);
      chk("miss1_no_lost", lock_lost, 0);
      bad(16'h5678);
      chk("miss2_locked", locked, 1);
      bad(16'h9ABC);
      chk("miss3_err", err_count, 3);
      chk("miss3_lock_lost", lock_lost, 1);
      chk("miss3_locked", locked, 0);
      chk("miss3_words", word_count, 3);
      drive(1'b0, 16'hFFFF, 1'b0);
      chk("lost_pulse_drop", lock_lost, 0);
      chk("idle_err_pulse", err_pulse, 0);
      repeat (4) good();
      chk("relock_after_4", locked, 0);
      good();
      chk("relock_after_5", locked, 1);
      chk("relock_words", word_count, 3);
      good();
      #2 resetn = 1'b0;
      #1;
      chk("async_rst_locked", locked, 0);
      chk("async_rst_words", word_count, 0);
      chk("async_rst_err", err_count, 0);
      #3 resetn = 1'b1;
      repeat (6) drive(1'b1, 16'h0000, 1'b0);
      chk("zero_stays_hunt", locked, 0);
      cur = 16'hACE1;
      for (int i = 0; i < 5; i++) begin
         repeat ($urandom_range(0, 7)) drive(1'b0, 16'hFFFF, 1'b0);
         good();
         chk("gap_lock", locked, i == 4);
      end
      for (int i = 0; i < 3; i++) begin
         repeat ($urandom_range(0, 7)) drive(1'b0, 16'hFFFF, 1'b0);
         chk("gap_idle_pulse", err_pulse, 0);
         good();
      end
      chk("gap_err_count", err_count, 0);
      chk("gap_words", word_count, 3);
      chk("gap_locked", locked, 1);
      drive(1'b1, cur ^ 16'h0001, 1'b1);
      cur = nxt(cur);
      chk("clr_err_pulse", err_pulse, 1);
      chk("clr_wins_err", err_count, 0);
      chk("clr_wins_words", word_count, 0);
      for (int i = 0; i < 16; i++) begin
         bad(cur ^ 16'h8000);
         good();
      end
      chk("sat16_err", err_count, 16);
      chk("sat4_err", ec4, 15);
      chk("sat32_words", word_count, 32);
      chk("sat4_words", wc4, 15);
      chk("sat_locked", locked, 1);
      bad(cur ^ 16'h0100);
      chk("sat4_hold_err", ec4, 15);
      chk("sat4_hold_pulse", e4, 1);
      chk("sat16_err_next", err_count, 17);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
